add_share_arbiter: RTL and testbench
====================================

ADD_SHARE_ARBITER -- requirements
Module: add_share_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, the number of requesters sharing one 32-bit adder, legal range 2..8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, N_REQ, one bit per requester: operands present.
REQ-005 The block SHALL have port req_a, input, 32*N_REQ, first operand; requester i occupies bits [32*i+31:32*i].
REQ-006 The block SHALL have port req_b, input, 32*N_REQ, second operand, packed the same way as req_a.
REQ-007 The block SHALL have port req_ready, output, N_REQ, one-hot or zero grant: the request is taken in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-008 The block SHALL have port resp_valid, output, 1, meaning the result register holds an undelivered result.
REQ-009 The block SHALL have port resp_ready, input, 1, the consumer accepts the result when resp_valid and resp_ready are both 1.
REQ-010 The block SHALL have port resp_sum, output, 32, the registered sum.
REQ-011 The block SHALL have port resp_carry, output, 1, the registered carry out of bit 31.
REQ-012 The block SHALL have port resp_id, output, 3, the index of the requester that owns the result.
REQ-013 The block SHALL have port op_count, output, 16, the number of results delivered since reset.

Function
REQ-014 The block SHALL contain exactly one 32-bit adder: carry-in 0, producing a 32-bit sum and a carry-out.
REQ-015 The result register SHALL be able to accept a new request ("slot free") when resp_valid=0, or when resp_valid=1 and resp_ready=1 in the same cycle.
REQ-016 When the slot is free, the block SHALL assert req_ready for exactly one requester: the first requester with req_valid high, searching upward from rr_ptr, modulo N_REQ.
REQ-017 When the slot is not free, or req_valid is all zero, req_ready SHALL be all zero.
REQ-018 req_ready SHALL depend combinationally on req_valid, rr_ptr and the slot-free condition only; it SHALL NOT depend on the operands.
REQ-019 On a grant to requester g, on the next edge, the block SHALL load resp_sum and resp_carry from req_a[g] + req_b[g], set resp_id=g and resp_valid=1, and set rr_ptr=(g+1) mod N_REQ.
REQ-020 Latency from a grant to resp_valid SHALL be one cycle.
REQ-021 Back-to-back grants SHALL give a throughput of one result per cycle while resp_ready stays 1.
REQ-022 While resp_valid=1 and resp_ready=0, resp_sum, resp_carry and resp_id SHALL hold stable, and no grant SHALL be issued.
REQ-023 When a delivery occurs and no grant occurs in the same cycle, resp_valid SHALL clear on the next edge.
REQ-024 When a delivery and a grant occur in the same cycle, resp_valid SHALL stay 1 and the register SHALL load the new result.
REQ-025 rr_ptr SHALL change only on a grant.
REQ-026 A requester that drops req_valid before it is granted SHALL lose nothing; no request state is stored for it.
REQ-027 op_count SHALL increment by 1 on every delivery and wrap from 0xFFFF to 0x0000.
REQ-028 Sum overflow SHALL wrap modulo 2^32 and set resp_carry=1; there is no signed overflow output.
REQ-029 resp_id SHALL be zero-extended to 3 bits; bits above ceil(log2(N_REQ)) SHALL read 0.

Reset
REQ-030 Under rst=1 on an edge, the block SHALL set resp_valid=0, resp_sum=0, resp_carry=0, resp_id=0, op_count=0 and rr_ptr=0.
REQ-031 While rst=1, req_ready SHALL be all zero.
REQ-032 Reset SHALL take priority over a simultaneous grant or delivery; a result pending at reset SHALL be discarded, not delivered.
REQ-033 In the first cycle after rst falls, the block SHALL be able to grant, with requester 0 at highest priority.

Verification
REQ-034 Single request: after reset, req_valid=0001, a=0x0000_0005, b=0x0000_0007, resp_ready=1 -> req_ready=0001 that cycle; next cycle resp_valid=1, resp_sum=0x0000_000C, resp_carry=0, resp_id=0, then op_count=1.
REQ-035 Carry: a=0xFFFF_FFFF, b=0x0000_0001 -> resp_sum=0x0000_0000, resp_carry=1; a=0x8000_0000, b=0x8000_0000 -> resp_sum=0, resp_carry=1.
REQ-036 Round robin: req_valid=1111 held, resp_ready=1, four cycles -> grants go 0,1,2,3 in order, resp_id follows 0,1,2,3 one cycle later, then the grant wraps to 0.
REQ-037 Backpressure: result pending, resp_ready=0 for 3 cycles with req_valid=0110 -> req_ready=0000 and resp_* stable; then resp_ready=1 -> same-cycle grant to the next requester in order and resp_valid stays 1.
REQ-038 Reset mid-operation: rst=1 while resp_valid=1 and resp_ready=1 -> next cycle resp_valid=0 and op_count=0; a grant after reset goes to requester 0 if it is valid.
REQ-039 Random bench: random valid, operand and ready patterns over 10k cycles -> every result equals a+b mod 2^32 with the correct carry and id, no request is granted twice, and no requester is starved beyond N_REQ grants.

Source files
------------

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: N_REQ requesters share one 32-bit adder.
// A rotating-priority arbiter picks one valid requester whenever the single
// result register is free (empty, or being drained this cycle). The winner's
// operands go through the one adder, and the sum is registered together with
// its carry and owner id. The result is held until the consumer takes it.
module add_share_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_sum,
  output logic                 resp_carry,
  output logic [2:0]           resp_id,
  output logic [15:0]          op_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);

  // Operands viewed as one 32-bit word per requester.
  logic [N_REQ-1:0][31:0] opa, opb;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign opa[g] = req_a[32*g +: 32];
    assign opb[g] = req_b[32*g +: 32];
  end

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] rr_next;
  logic             found;
  logic             slot_free;
  logic             grant;
  logic             deliver;
  logic [31:0]      add_sum;
  logic             add_carry;

  // The register can take a new result if empty or being drained right now.
  assign slot_free = !resp_valid || resp_ready;
  assign deliver   = resp_valid && resp_ready;

  // Rotating search: first valid requester at or above rr_ptr, wrapping.
  // Only req_valid and rr_ptr feed this; operands never affect the grant.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
      cand = (cand == LAST) ? '0 : cand + 1'b1;
    end
  end

  // Grant is suppressed during reset and while the result is stalled.
  assign grant     = found && slot_free && !rst;
  assign req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;

  // The one shared adder, carry-in 0, fed by the winner's operands.
  assign {add_carry, add_sum} = {1'b0, opa[gnt_idx]} + {1'b0, opb[gnt_idx]};

  assign rr_next = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

  // Result register, round-robin pointer and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_carry <= 1'b0;
      resp_id    <= '0;
      op_count   <= '0;
      rr_ptr     <= '0;
    end else begin
      if (grant) begin
        resp_valid <= 1'b1;
        resp_sum   <= add_sum;
        resp_carry <= add_carry;
        resp_id    <= 3'(gnt_idx);
        rr_ptr     <= rr_next;
      end else if (deliver) begin
        resp_valid <= 1'b0;
      end
      if (deliver) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction model.
module tb_add_share_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [32*N-1:0]  req_a = '0;
  logic [32*N-1:0]  req_b = '0;
  logic [N-1:0]     req_ready;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [31:0]      resp_sum;
  logic             resp_carry;
  logic [2:0]       resp_id;
  logic [15:0]      op_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add_share_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_carry(resp_carry), .resp_id(resp_id),
    .op_count(op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000 | $urandom;
      default: return $urandom;
    endcase
  endfunction

  // Transaction-level model: one pending result, a priority pointer, a count.
  bit        m_vld = 0;
  bit [31:0] m_sum = 0;
  bit        m_carry = 0;
  int        m_id = 0;
  int        m_rr = 0;
  int        m_cnt = 0;
  int        wait_n[N];

  // Compare the DUT to the model on every falling edge, then advance the model.
  always @(negedge clk) begin
    int g;
    bit [N-1:0] exp_rdy;
    bit [32:0] full;
    g = -1;
    if (!rst && (!m_vld || resp_ready)) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("resp_valid", 32'(resp_valid), 32'(m_vld));
    check("resp_sum", resp_sum, m_sum);
    check("resp_carry", 32'(resp_carry), 32'(m_carry));
    check("resp_id", 32'(resp_id), 32'(m_id));
    check("op_count", 32'(op_count), 32'(m_cnt));
    // A continuously waiting requester may see at most N-1 others served first.
    for (int i = 0; i < N; i++) begin
      if (rst || !req_valid[i] || i == g) wait_n[i] = 0;
      else if (g >= 0) begin
        wait_n[i]++;
        n_chk++;
        if (wait_n[i] > N - 1) begin
          n_fail++;
          $display("FAIL starvation: requester %0d waited %0d grants, limit %0d", i, wait_n[i], N - 1);
        end
      end
    end
    if (rst) begin
      m_vld = 0; m_sum = 0; m_carry = 0; m_id = 0; m_rr = 0; m_cnt = 0;
    end else begin
      if (m_vld && resp_ready) m_cnt = (m_cnt + 1) % 65536;
      if (g >= 0) begin
        full    = {1'b0, req_a[32*g +: 32]} + {1'b0, req_b[32*g +: 32]};
        m_sum   = full[31:0];
        m_carry = full[32];
        m_id    = g;
        m_vld   = 1;
        m_rr    = (g + 1) % N;
      end else if (m_vld && resp_ready) begin
        m_vld = 0;
      end
    end
  end

  // Directed scenarios with hand-computed values, then random traffic.
  initial begin
    logic [N-1:0] gp;
    for (int i = 0; i < N; i++) wait_n[i] = 0;
    rst = 1; resp_ready = 1; req_valid = 4'b0001;
    req_a[31:0] = 32'h0000_0005; req_b[31:0] = 32'h0000_0007;
    cyc(); cyc();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_count", 32'(op_count), 32'h0);

    // Single request
    cyc(); rst = 0;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    @(negedge clk);
    check("single_valid", 32'(resp_valid), 32'h1);
    check("single_sum", resp_sum, 32'h0000_000C);
    check("single_carry", 32'(resp_carry), 32'h0);
    check("single_id", 32'(resp_id), 32'h0);
    cyc();
    @(negedge clk);
    check("single_count", 32'(op_count), 32'h1);
    check("single_drain", 32'(resp_valid), 32'h0);

    // Carry cases, second one granted in the same cycle the first is delivered
    cyc(); req_valid = 4'b0001; req_a[31:0] = 32'hFFFF_FFFF; req_b[31:0] = 32'h0000_0001;
    cyc(); req_a[31:0] = 32'h8000_0000; req_b[31:0] = 32'h8000_0000;
    @(negedge clk);
    check("carry1_sum", resp_sum, 32'h0);
    check("carry1_carry", 32'(resp_carry), 32'h1);
    cyc(); req_valid = '0;
    @(negedge clk);
    check("carry2_sum", resp_sum, 32'h0);
    check("carry2_carry", 32'(resp_carry), 32'h1);
    check("carry2_valid", 32'(resp_valid), 32'h1);
    check("carry2_count", 32'(op_count), 32'h2);

    // Round robin from a fresh reset with all four requesting
    cyc(); rst = 1;
    cyc(); rst = 0; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = i;
      req_b[32*i +: 32] = 10 * i;
    end
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) begin
        check("rr_id", 32'(resp_id), k - 1);
        check("rr_sum", resp_sum, 11 * (k - 1));
      end
      cyc();
    end

    // Backpressure: result from requester 0 stalls, 1 and 2 waiting
    req_valid = 4'b0110; resp_ready = 0;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 32'h0);
      check("bp_valid", 32'(resp_valid), 32'h1);
      check("bp_id", 32'(resp_id), 32'h0);
      check("bp_sum", resp_sum, 32'h0);
      cyc();
    end
    resp_ready = 1;
    @(negedge clk);
    check("bp_release", 32'(req_ready), 32'h2);
    cyc(); rst = 1; req_valid = 4'b0001;
    @(negedge clk);
    check("bp_next_valid", 32'(resp_valid), 32'h1);
    check("bp_next_id", 32'(resp_id), 32'h1);
    check("bp_next_sum", resp_sum, 32'd11);
    check("rst_mid_ready", 32'(req_ready), 32'h0);

    // Reset with a result pending discards it
    cyc(); rst = 0;
    @(negedge clk);
    check("rst_mid_valid", 32'(resp_valid), 32'h0);
    check("rst_mid_count", 32'(op_count), 32'h0);
    check("rst_mid_grant", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    @(negedge clk);
    check("rst_mid_id", 32'(resp_id), 32'h0);
    check("rst_mid_resp", 32'(resp_valid), 32'h1);

    // Random traffic; requests are held until granted unless dropped
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      gp = req_ready;
      cyc();
      resp_ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(499) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || gp[i]) begin
          req_valid[i] = $urandom_range(1);
          req_a[32*i +: 32] = rnd_op();
          req_b[32*i +: 32] = rnd_op();
        end else if ($urandom_range(19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    cyc(); rst = 0; req_valid = '0;
    @(negedge clk);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
